// File: rtl/vbuffer_pkg.sv
// Shared types and elaboration helpers for the ping-pong pixel word buffer.
package vbuffer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } rd_state_t;

   // Bytes per packed word.
   function automatic int unsigned wsize_of(input int unsigned bpp, input int unsigned psize);
      return (bpp * psize) / 8;
   endfunction

   // A packed word must fill a whole number of bytes.
   function automatic bit packs_to_bytes(input int unsigned bpp, input int unsigned psize);
      return ((bpp * psize) % 8) == 0;
   endfunction

   // Index width, never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vbuffer_bank.sv
// One WSIZE x 8 byte bank with a write port and a combinational unpack to pixels.
module vbuffer_bank
   import vbuffer_pkg::*;
#(
   parameter int unsigned BPP   = 6,
   parameter int unsigned PSIZE = 4,
   parameter int unsigned WSIZE = 3
) (
   input  logic                       PixelClk,
   input  logic                       we,
   input  logic [idx_w(WSIZE)-1:0]    addr,
   input  logic [7:0]                 din,
   output logic [PSIZE-1:0][BPP-1:0]  pixels
);

   logic [7:0]         mem [WSIZE];
   logic [WSIZE*8-1:0] word;

   always_ff @(posedge PixelClk) begin
      if (we) mem[addr] <= din;
   end

   // Little-endian: byte 0 holds the lowest pixel bits.
   always_comb begin
      word = '0;
      for (int unsigned i = 0; i < WSIZE; i++) word[i*8 +: 8] = mem[i];
   end

   assign pixels = word;

endmodule

// File: rtl/vbuffer_pp.sv
// Double-buffered pixel word buffer: bytes fill the back bank while pixels drain from the front.
module vbuffer_pp
   import vbuffer_pkg::*;
#(
   parameter int unsigned BPP   = 6,
   parameter int unsigned PSIZE = 4
) (
   input  logic           PixelClk,
   input  logic           Reset,
   input  logic           WriteEn,
   input  logic [7:0]     DataIn,
   input  logic           PixelEn,
   input  logic           Blank,
   output logic           FillReq,
   output logic           Underrun,
   output logic           Overflow,
   output logic [BPP-1:0] VideoOut,
   output logic           VideoValid
);

   localparam int unsigned WSIZE   = wsize_of(BPP, PSIZE);
   localparam int unsigned AW      = idx_w(WSIZE);
   localparam int unsigned IW      = idx_w(PSIZE);
   localparam bit          PACK_OK = packs_to_bytes(BPP, PSIZE);

   if (!PACK_OK) begin : g_bad_packing
      $error("vbuffer_pp: BPP*PSIZE must be a multiple of 8");
   end

   rd_state_t                state, state_nxt;
   logic                     sel;
   logic                     back_full;
   logic [AW-1:0]            wr_cnt;
   logic [IW-1:0]            rd_idx, idx_nxt;
   logic                     consume, swap, wr_ok, last_byte, back_post;
   logic [BPP-1:0]           vo_nxt;
   logic                     vv_nxt;
   logic [PSIZE-1:0][BPP-1:0] pix0, pix1, front_pix;

   assign consume   = PixelEn && !Blank;
   assign front_pix = sel ? pix1 : pix0;
   assign FillReq   = !back_full;

   // A swap frees the old front bank in the same cycle, so a write then lands
   // there (back_post) instead of being rejected as an overflow.
   assign back_post = swap ? sel : ~sel;
   assign wr_ok     = WriteEn && (!back_full || swap);
   assign Overflow  = WriteEn && back_full && !swap;
   assign last_byte = wr_ok && (wr_cnt == AW'(WSIZE - 1));

   vbuffer_bank #(.BPP(BPP), .PSIZE(PSIZE), .WSIZE(WSIZE)) u_bank0 (
      .PixelClk (PixelClk),
      .we       (wr_ok && !back_post),
      .addr     (wr_cnt),
      .din      (DataIn),
      .pixels   (pix0)
   );

   vbuffer_bank #(.BPP(BPP), .PSIZE(PSIZE), .WSIZE(WSIZE)) u_bank1 (
      .PixelClk (PixelClk),
      .we       (wr_ok && back_post),
      .addr     (wr_cnt),
      .din      (DataIn),
      .pixels   (pix1)
   );

   always_comb begin
      state_nxt = state;
      idx_nxt   = rd_idx;
      swap      = 1'b0;
      Underrun  = 1'b0;
      vo_nxt    = VideoOut;
      vv_nxt    = VideoValid;
      if (Blank) begin
         vo_nxt = '0;
         vv_nxt = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (consume) begin
                  Underrun = 1'b1;
                  vo_nxt   = '0;
                  vv_nxt   = 1'b0;
               end
               if (back_full) begin
                  swap      = 1'b1;
                  idx_nxt   = '0;
                  state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               if (consume) begin
                  vo_nxt = front_pix[rd_idx];
                  vv_nxt = 1'b1;
                  if (rd_idx == IW'(PSIZE - 1)) begin
                     idx_nxt = '0;
                     if (back_full) swap = 1'b1;
                     else           state_nxt = ST_IDLE;
                  end else begin
                     idx_nxt = rd_idx + 1'b1;
                  end
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge PixelClk or posedge Reset) begin
      if (Reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge PixelClk or posedge Reset) begin
      if (Reset) begin
         sel        <= 1'b0;
         back_full  <= 1'b0;
         wr_cnt     <= '0;
         rd_idx     <= '0;
         VideoOut   <= '0;
         VideoValid <= 1'b0;
      end else begin
         rd_idx     <= idx_nxt;
         VideoOut   <= vo_nxt;
         VideoValid <= vv_nxt;
         if (swap) sel <= ~sel;
         if (last_byte) begin
            back_full <= 1'b1;
            wr_cnt    <= '0;
         end else begin
            if (swap)  back_full <= 1'b0;
            if (wr_ok) wr_cnt    <= wr_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vbuffer_pp.sv
// Table-driven bench for vbuffer_pp with a scoreboard queue for registered pixel output.
module tb_vbuffer_pp;

   localparam int unsigned BPP   = 6;
   localparam int unsigned PSIZE = 4;

   logic           PixelClk = 1'b0;
   logic           Reset;
   logic           WriteEn;
   logic [7:0]     DataIn;
   logic           PixelEn;
   logic           Blank;
   logic           FillReq;
   logic           Underrun;
   logic           Overflow;
   logic [BPP-1:0] VideoOut;
   logic           VideoValid;

   int checks   = 0;
   int failures = 0;

   vbuffer_pp #(.BPP(BPP), .PSIZE(PSIZE)) dut (
      .PixelClk   (PixelClk),
      .Reset      (Reset),
      .WriteEn    (WriteEn),
      .DataIn     (DataIn),
      .PixelEn    (PixelEn),
      .Blank      (Blank),
      .FillReq    (FillReq),
      .Underrun   (Underrun),
      .Overflow   (Overflow),
      .VideoOut   (VideoOut),
      .VideoValid (VideoValid)
   );

   always #5 PixelClk = ~PixelClk;

   typedef struct {
      logic           we;
      logic [7:0]     d;
      logic           pe;
      logic           bl;
      logic           fr;
      logic           uf;
      logic           ov;
      logic           ev;
      logic [BPP-1:0] epx;
   } vec_t;

   typedef struct {
      logic           v;
      logic [BPP-1:0] px;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   function automatic logic [BPP-1:0] px(input logic [23:0] w, input int i);
      logic [23:0] s;
      s = w >> (i * BPP);
      return s[BPP-1:0];
   endfunction

   function automatic void add(input logic we, input logic [7:0] d, input logic pe, input logic bl,
                               input logic fr, input logic uf, input logic ov,
                               input logic ev, input logic [BPP-1:0] epx);
      vec_t v;
      v.we = we; v.d = d; v.pe = pe; v.bl = bl;
      v.fr = fr; v.uf = uf; v.ov = ov; v.ev = ev; v.epx = epx;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [7:0] d, input logic pe, input logic bl);
      WriteEn = we; DataIn = d; PixelEn = pe; Blank = bl;
      #1;
   endtask

   task automatic tick();
      @(posedge PixelClk);
      #1;
   endtask

   localparam logic [23:0] W2 = 24'h332211;
   localparam logic [23:0] W3 = 24'h665544;
   localparam logic [23:0] W4 = 24'h998877;
   localparam logic [23:0] W5 = 24'hCCBBAA;
   localparam logic [23:0] W6 = 24'h7EC35A;
   localparam logic [23:0] W8 = 24'h605047;

   initial begin
      exp_t e;

      // we d pe bl | fillreq underrun overflow | valid pixel (after the edge)
      add(1, 8'hA5, 0, 0, 1, 0, 0, 0, 6'h00);
      add(1, 8'h3C, 0, 0, 1, 0, 0, 0, 6'h00);
      add(1, 8'hF0, 0, 0, 1, 0, 0, 0, 6'h00);
      add(0, 8'h00, 0, 0, 0, 0, 0, 0, 6'h00);
      add(0, 8'h00, 1, 0, 1, 0, 0, 1, 6'h25);
      add(0, 8'h00, 1, 0, 1, 0, 0, 1, 6'h32);
      add(0, 8'h00, 1, 0, 1, 0, 0, 1, 6'h03);
      add(0, 8'h00, 1, 0, 1, 0, 0, 1, 6'h3C);
      add(0, 8'h00, 0, 0, 1, 0, 0, 1, 6'h3C);
      add(0, 8'h00, 1, 0, 1, 1, 0, 0, 6'h00);
      add(0, 8'h00, 1, 0, 1, 1, 0, 0, 6'h00);
      add(1, 8'h11, 1, 0, 1, 1, 0, 0, 6'h00);
      add(1, 8'h22, 1, 0, 1, 1, 0, 0, 6'h00);
      add(1, 8'h33, 1, 0, 1, 1, 0, 0, 6'h00);
      add(0, 8'h00, 1, 0, 0, 1, 0, 0, 6'h00);
      add(0, 8'h00, 1, 0, 1, 0, 0, 1, px(W2, 0));
      add(1, 8'h44, 1, 0, 1, 0, 0, 1, px(W2, 1));
      add(1, 8'h55, 1, 0, 1, 0, 0, 1, px(W2, 2));
      add(1, 8'h66, 1, 0, 1, 0, 0, 1, px(W2, 3));
      add(0, 8'h00, 1, 0, 0, 1, 0, 0, 6'h00);
      add(1, 8'h77, 1, 0, 1, 0, 0, 1, px(W3, 0));
      add(1, 8'h88, 1, 0, 1, 0, 0, 1, px(W3, 1));
      add(1, 8'h99, 1, 0, 1, 0, 0, 1, px(W3, 2));
      add(1, 8'hAA, 1, 0, 0, 0, 0, 1, px(W3, 3));
      add(1, 8'hBB, 1, 0, 1, 0, 0, 1, px(W4, 0));
      add(1, 8'hCC, 1, 0, 1, 0, 0, 1, px(W4, 1));
      add(1, 8'hDD, 1, 0, 0, 0, 1, 1, px(W4, 2));
      add(0, 8'h00, 1, 0, 0, 0, 0, 1, px(W4, 3));
      add(0, 8'h00, 1, 0, 1, 0, 0, 1, px(W5, 0));
      add(0, 8'h00, 1, 0, 1, 0, 0, 1, px(W5, 1));
      add(0, 8'h00, 1, 0, 1, 0, 0, 1, px(W5, 2));
      add(0, 8'h00, 1, 0, 1, 0, 0, 1, px(W5, 3));
      add(1, 8'h5A, 0, 0, 1, 0, 0, 1, px(W5, 3));
      add(1, 8'hC3, 0, 0, 1, 0, 0, 1, px(W5, 3));
      add(1, 8'h7E, 0, 0, 1, 0, 0, 1, px(W5, 3));
      add(0, 8'h00, 0, 0, 0, 0, 0, 1, px(W5, 3));
      add(0, 8'h00, 1, 0, 1, 0, 0, 1, px(W6, 0));
      add(0, 8'h00, 1, 0, 1, 0, 0, 1, px(W6, 1));
      for (int i = 0; i < 5; i++) add(0, 8'h00, 1, 1, 1, 0, 0, 0, 6'h00);
      add(0, 8'h00, 1, 0, 1, 0, 0, 1, px(W6, 2));
      add(0, 8'h00, 1, 0, 1, 0, 0, 1, px(W6, 3));
      add(0, 8'h00, 1, 1, 1, 0, 0, 0, 6'h00);
      add(0, 8'h00, 1, 0, 1, 1, 0, 0, 6'h00);

      Reset = 1'b1;
      drive(0, 8'h00, 0, 0);
      tick();
      tick();
      Reset = 1'b0;
      #1;
      chk("reset_fillreq",  {7'd0, FillReq},    8'd1);
      chk("reset_valid",    {7'd0, VideoValid}, 8'd0);
      chk("reset_videoout", {2'd0, VideoOut},   8'd0);
      chk("reset_underrun", {7'd0, Underrun},   8'd0);
      chk("reset_overflow", {7'd0, Overflow},   8'd0);
      tick();

      foreach (vecs[n]) begin
         drive(vecs[n].we, vecs[n].d, vecs[n].pe, vecs[n].bl);
         e.v  = vecs[n].ev;
         e.px = vecs[n].epx;
         sb.push_back(e);
         chk($sformatf("v%0d_fillreq", n),  {7'd0, FillReq},  {7'd0, vecs[n].fr});
         chk($sformatf("v%0d_underrun", n), {7'd0, Underrun}, {7'd0, vecs[n].uf});
         chk($sformatf("v%0d_overflow", n), {7'd0, Overflow}, {7'd0, vecs[n].ov});
         tick();
         e = sb.pop_front();
         chk($sformatf("v%0d_valid", n),    {7'd0, VideoValid}, {7'd0, e.v});
         chk($sformatf("v%0d_videoout", n), {2'd0, VideoOut},   {2'd0, e.px});
      end

      // Reset mid-fill with a live front word: both must be discarded.
      drive(1, 8'h01, 0, 0); tick();
      drive(1, 8'h02, 0, 0); tick();
      drive(1, 8'h03, 0, 0); tick();
      drive(0, 8'h00, 0, 0); tick();
      drive(0, 8'h00, 1, 0); tick();
      chk("pre_reset_pixel", {2'd0, VideoOut}, 8'h01);
      drive(1, 8'h10, 0, 0); tick();
      drive(1, 8'h20, 0, 0);
      Reset = 1'b1;
      #1;
      chk("midfill_reset_fillreq", {7'd0, FillReq},    8'd1);
      chk("midfill_reset_valid",   {7'd0, VideoValid}, 8'd0);
      chk("midfill_reset_vout",    {2'd0, VideoOut},   8'd0);
      tick();
      Reset = 1'b0;
      drive(0, 8'h00, 1, 0);
      chk("post_reset_underrun", {7'd0, Underrun}, 8'd1);
      tick();
      drive(1, 8'h47, 0, 0); tick();
      drive(1, 8'h50, 0, 0); tick();
      chk("post_reset_fillreq_partial", {7'd0, FillReq}, 8'd1);
      drive(1, 8'h60, 0, 0); tick();
      drive(0, 8'h00, 0, 0);
      chk("post_reset_fillreq_full", {7'd0, FillReq}, 8'd0);
      tick();
      drive(0, 8'h00, 1, 0); tick();
      chk("post_reset_valid", {7'd0, VideoValid}, 8'd1);
      chk("post_reset_pixel", {2'd0, VideoOut},   {2'd0, px(W8, 0)});
      drive(0, 8'h00, 1, 0); tick();
      chk("post_reset_pixel1", {2'd0, VideoOut},  {2'd0, px(W8, 1)});
      drive(0, 8'h00, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
